// File: rtl/posit_construction_pipe.sv
// Packs sign/regime/exponent/fraction fields into a posit word; two register stages, 2-cycle latency.
// Valid/ready: a stage loads when empty or when the stage after it loads; a flush kills both stages.
module posit_construction_pipe #(
    parameter int WIDTH = 32,
    parameter int ES    = 2,
    parameter int RS    = $clog2(WIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                sign_i,
    input  logic signed [RS:0]  k_i,
    input  logic [ES-1:0]       exp_i,
    input  logic [WIDTH-1:0]    mant_i,
    input  logic                nar_i,
    input  logic                zero_i,
    input  logic [2:0]          rnd_mode_i,
    input  logic                tag_i,
    input  logic                flush_i,
    output logic [WIDTH-1:0]    result_o,
    output logic                tag_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o
);

    localparam int PAD = 2**RS;
    localparam int TW  = 2 + ES + WIDTH + PAD;
    localparam int KW  = WIDTH - 1;
    localparam logic signed [RS:0] K_MAX = (RS+1)'(WIDTH - 2);
    localparam logic signed [RS:0] K_MIN = (RS+1)'(-(WIDTH - 2));

    logic                r_s1_vld;
    logic [KW-1:0]       r_s1_kept;
    logic                r_s1_guard;
    logic                r_s1_sticky;
    logic                r_s1_sign;
    logic                r_s1_nar;
    logic                r_s1_zero;
    logic                r_s1_rtz;
    logic                r_s1_tag;
    logic                r_s2_vld;
    logic [WIDTH-1:0]    r_s2_res;
    logic                r_s2_tag;

    logic                w_s2_load;
    logic                w_s1_load;
    logic                w_s1_take;
    logic [RS-1:0]       w_shamt;
    logic signed [TW-1:0] w_seed;
    logic signed [TW-1:0] w_body;
    logic                w_sat_hi;
    logic                w_sat_lo;
    logic                w_inc;
    logic [KW-1:0]       w_rounded;
    logic [WIDTH-1:0]    w_mag;
    logic [WIDTH-1:0]    w_res;

    assign w_s2_load  = !r_s2_vld || out_ready_i;
    assign w_s1_load  = !r_s1_vld || w_s2_load;
    assign in_ready_o = w_s1_load && !flush_i;
    assign w_s1_take  = in_valid_i && in_ready_o;

    // Seeding "10" (k>=0) or "01" (k<0) and sign-extending by k or -k-1 yields the regime run.
    assign w_shamt  = k_i[RS] ? ~k_i[RS-1:0] : k_i[RS-1:0];
    assign w_seed   = {~k_i[RS], k_i[RS], exp_i, mant_i, {PAD{1'b0}}};
    assign w_body   = w_seed >>> w_shamt;
    assign w_sat_hi = (k_i >= K_MAX);
    assign w_sat_lo = (k_i <= K_MIN);

    // An all-ones body is maxpos; rounding it up would wrap into NaR.
    assign w_inc     = !r_s1_rtz && r_s1_guard && (r_s1_sticky || r_s1_kept[0]) && !(&r_s1_kept);
    assign w_rounded = r_s1_kept + {{(KW-1){1'b0}}, w_inc};
    assign w_mag     = {1'b0, w_rounded};

    always_comb begin
        w_res = w_mag;
        if (r_s1_nar)
            w_res = {1'b1, {KW{1'b0}}};
        else if (r_s1_zero)
            w_res = '0;
        else if (r_s1_sign)
            w_res = -w_mag;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_vld    <= 1'b0;
            r_s1_kept   <= '0;
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_nar    <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_rtz    <= 1'b0;
            r_s1_tag    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_res    <= '0;
            r_s2_tag    <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s1_vld <= 1'b0;
                r_s2_vld <= 1'b0;
            end else begin
                if (w_s2_load) r_s2_vld <= r_s1_vld;
                if (w_s1_load) r_s1_vld <= in_valid_i;
            end

            if (w_s1_take) begin
                if (w_sat_hi)
                    r_s1_kept <= '1;
                else if (w_sat_lo)
                    r_s1_kept <= {{(KW-1){1'b0}}, 1'b1};
                else
                    r_s1_kept <= w_body[TW-1 -: KW];
                r_s1_guard  <= !w_sat_hi && !w_sat_lo && w_body[TW-1-KW];
                r_s1_sticky <= !w_sat_hi && !w_sat_lo && (|w_body[TW-2-KW:0]);
                r_s1_sign   <= sign_i;
                r_s1_nar    <= nar_i;
                r_s1_zero   <= zero_i;
                r_s1_rtz    <= (rnd_mode_i == 3'b001);
                r_s1_tag    <= tag_i;
            end

            if (w_s2_load && r_s1_vld && !flush_i) begin
                r_s2_res <= w_res;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    assign result_o    = r_s2_res;
    assign tag_o       = r_s2_tag;
    assign out_valid_o = r_s2_vld;
    assign busy_o      = r_s1_vld || r_s2_vld;

endmodule

// File: tb/tb_posit_construction_pipe.sv
// Scoreboard bench for posit_construction_pipe: expected words queued on acceptance, compared on output.
module tb_posit_construction_pipe;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic               sign_i = 1'b0;
    logic signed [5:0]  k_i = '0;
    logic [1:0]         exp_i = '0;
    logic [31:0]        mant_i = '0;
    logic               nar_i = 1'b0;
    logic               zero_i = 1'b0;
    logic [2:0]         rnd_mode_i = '0;
    logic               tag_i = 1'b0;
    logic               flush_i = 1'b0;
    logic [31:0]        result_o;
    logic               tag_o;
    logic               out_valid_o;
    logic               out_ready_i = 1'b1;
    logic               busy_o;

    typedef struct {
        logic [31:0] res;
        logic        tag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        got;
    logic [31:0] drv_exp = '0;
    logic        drv_tag = 1'b0;
    int          n_checks = 0;
    int          n_errs = 0;
    int          occ = 0;
    int          n_out = 0;
    int          rdy_mode = 0;
    int          rcyc = 0;
    int          n_base;

    posit_construction_pipe dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sign_i      (sign_i),
        .k_i         (k_i),
        .exp_i       (exp_i),
        .mant_i      (mant_i),
        .nar_i       (nar_i),
        .zero_i      (zero_i),
        .rnd_mode_i  (rnd_mode_i),
        .tag_i       (tag_i),
        .flush_i     (flush_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference encoder: writes the posit bit string out one bit at a time.
    function automatic logic [31:0] model(input logic s, input int k, input logic [1:0] e,
                                          input logic [31:0] m, input logic nar, input logic zr,
                                          input logic [2:0] rm);
        logic [127:0] bits;
        logic [30:0]  kept;
        logic         g;
        logic         st;
        logic [31:0]  mag;
        int           pos;
        if (nar) return 32'h8000_0000;
        if (zr) return 32'h0000_0000;
        if (k >= 30) mag = 32'h7FFF_FFFF;
        else if (k <= -30) mag = 32'h0000_0001;
        else begin
            bits = '0;
            pos = 127;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin bits[pos] = 1'b1; pos--; end
                bits[pos] = 1'b0; pos--;
            end else begin
                for (int i = 0; i < -k; i++) begin bits[pos] = 1'b0; pos--; end
                bits[pos] = 1'b1; pos--;
            end
            for (int i = 1; i >= 0; i--) begin bits[pos] = e[i]; pos--; end
            for (int i = 31; i >= 0; i--) begin bits[pos] = m[i]; pos--; end
            kept = bits[127:97];
            g    = bits[96];
            st   = |bits[95:0];
            if (rm != 3'b001 && g && (st || kept[0])) kept = kept + 31'd1;
            mag = {1'b0, kept};
        end
        return s ? -mag : mag;
    endfunction

    task automatic send(input logic s, input int k, input logic [1:0] e, input logic [31:0] m,
                        input logic nar, input logic zr, input logic [2:0] rm, input logic tg,
                        input logic [31:0] ex);
        bit ok;
        ok = 0;
        sign_i = s; k_i = 6'(k); exp_i = e; mant_i = m; nar_i = nar; zero_i = zr;
        rnd_mode_i = rm; tag_i = tg; drv_exp = ex; drv_tag = tg; in_valid_i = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1;
                @(posedge clk_i);
                #1;
            end
        end
        if (!ok) check("send_timeout", {31'b0, in_ready_o}, 32'd1);
    endtask

    task automatic sendm(input logic s, input int k, input logic [1:0] e, input logic [31:0] m,
                         input logic nar, input logic zr, input logic [2:0] rm, input logic tg);
        send(s, k, e, m, nar, zr, rm, tg, model(s, k, e, m, nar, zr, rm));
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_i);
        #1;
        check("drain", exp_q.size(), 32'd0);
    endtask

    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = (rcyc % 3 == 0);
            default: out_ready_i = 1'b0;
        endcase
        rcyc++;
    end

    // Tracks pipeline occupancy from the handshakes and scores every output transfer.
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            occ = 0;
        end else if (flush_i) begin
            check("flush_rdy", {31'b0, in_ready_o}, 32'd0);
            exp_q.delete();
            occ = 0;
        end else begin
            check("in_ready", {31'b0, in_ready_o}, {31'b0, !(occ == 2 && !out_ready_i)});
            check("busy", {31'b0, busy_o}, {31'b0, occ != 0});
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexp_out", {31'b0, out_valid_o}, 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    check("result", result_o, got.res);
                    check("tag", {31'b0, tag_o}, {31'b0, got.tag});
                    n_out++;
                end
                occ--;
            end
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back('{res: drv_exp, tag: drv_tag});
                occ++;
            end
        end
    end

    initial begin
        #2;
        check("rst_vld", {31'b0, out_valid_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_res", result_o, 32'd0);
        check("rst_tag", {31'b0, tag_o}, 32'd0);
        #20;
        rst_i = 1'b0;
        tick(1);

        send(0, 0, 2'd0, 32'h0000_0000, 0, 0, 3'b000, 0, 32'h4000_0000);
        send(1, 0, 2'd0, 32'h0000_0000, 0, 0, 3'b000, 1, 32'hC000_0000);
        send(0, 0, 2'd1, 32'h1C00_0000, 0, 0, 3'b000, 0, 32'h48E0_0000);
        send(0, 0, 2'd0, 32'h0000_0010, 0, 0, 3'b000, 1, 32'h4000_0000);
        send(0, 0, 2'd0, 32'h0000_0030, 0, 0, 3'b000, 0, 32'h4000_0002);
        send(0, 0, 2'd0, 32'h0000_0030, 0, 0, 3'b001, 1, 32'h4000_0001);
        send(0, 0, 2'd0, 32'h0000_0030, 0, 0, 3'b101, 0, 32'h4000_0002);
        send(0, 31, 2'd3, 32'hFFFF_FFFF, 0, 0, 3'b000, 1, 32'h7FFF_FFFF);
        send(0, -31, 2'd0, 32'h0000_0000, 0, 0, 3'b000, 0, 32'h0000_0001);
        send(0, 30, 2'd0, 32'h0000_0000, 0, 0, 3'b000, 1, 32'h7FFF_FFFF);
        send(0, -30, 2'd3, 32'hFFFF_FFFF, 0, 0, 3'b000, 0, 32'h0000_0001);
        send(1, 31, 2'd0, 32'h0000_0000, 0, 0, 3'b000, 1, 32'h8000_0001);
        send(0, 0, 2'd0, 32'h1234_5678, 1, 1, 3'b000, 0, 32'h8000_0000);
        send(1, 5, 2'd2, 32'h1234_5678, 0, 1, 3'b001, 1, 32'h0000_0000);
        send(1, -3, 2'd1, 32'hFFFF_0000, 1, 0, 3'b001, 0, 32'h8000_0000);
        sendm(0, 29, 2'd3, 32'hFFFF_FFFF, 0, 0, 3'b000, 1);
        sendm(1, -29, 2'd0, 32'h0000_0000, 0, 0, 3'b000, 0);
        sendm(0, 27, 2'd2, 32'h8000_0000, 0, 0, 3'b000, 1);
        sendm(1, -7, 2'd2, 32'hABCD_EF01, 0, 0, 3'b001, 0);
        idle();
        drain();

        rdy_mode = 1;
        n_base = n_out;
        for (int i = 0; i < 8; i++)
            sendm($urandom_range(0, 1), int'($urandom_range(0, 63)) - 32, 2'($urandom_range(0, 3)),
                  $urandom, 0, 0, 3'($urandom_range(0, 7)), i[0]);
        idle();
        drain();
        check("stream_cnt", n_out - n_base, 32'd8);

        rdy_mode = 0;
        for (int i = 0; i < 16; i++)
            sendm($urandom_range(0, 1), int'($urandom_range(0, 56)) - 28, 2'($urandom_range(0, 3)),
                  $urandom, 0, 0, 3'($urandom_range(0, 1)), i[1]);
        idle();
        drain();

        rdy_mode = 2;
        tick(2);
        sendm(0, 2, 2'd1, 32'h5555_0000, 0, 0, 3'b000, 1);
        sendm(1, -2, 2'd2, 32'h0F0F_0000, 0, 0, 3'b000, 0);
        idle();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_vld", {31'b0, out_valid_o}, 32'd0);
        check("flush_busy", {31'b0, busy_o}, 32'd0);
        rdy_mode = 0;
        tick(1);
        sendm(0, 3, 2'd3, 32'hC000_0000, 0, 0, 3'b000, 1);
        idle();
        @(negedge clk_i);
        check("lat1_vld", {31'b0, out_valid_o}, 32'd0);
        @(negedge clk_i);
        check("lat2_vld", {31'b0, out_valid_o}, 32'd1);
        drain();

        rdy_mode = 2;
        tick(2);
        sendm(0, 1, 2'd1, 32'h8000_0000, 0, 0, 3'b000, 1);
        sendm(1, 4, 2'd3, 32'h7000_0000, 0, 0, 3'b000, 1);
        idle();
        check("full_vld", {31'b0, out_valid_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_vld", {31'b0, out_valid_o}, 32'd0);
        check("arst_busy", {31'b0, busy_o}, 32'd0);
        check("arst_res", result_o, 32'd0);
        check("arst_tag", {31'b0, tag_o}, 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        rdy_mode = 0;
        tick(1);
        n_base = n_out;
        sendm(0, -5, 2'd2, 32'h2468_ACE0, 0, 0, 3'b000, 0);
        idle();
        drain();
        check("post_rst_cnt", n_out - n_base, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/posit_construction_pipe.md
POSIT_CONSTRUCTION_PIPE -- requirements
Module: posit_construction_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, posit word width.
REQ-002 SHALL have parameter ES, default 2, exponent field width.
REQ-003 SHALL have parameter RS, default $clog2(WIDTH), regime-count width; k is RS+1 bits signed.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, as the ports below define.
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 in_valid_i  in  1  input fields valid.
REQ-008 in_ready_o  out  1  block accepts the input this cycle.
REQ-009 sign_i  in  1  sign of magnitude.
REQ-010 k_i  in  RS+1  signed regime value; useed = 16.
REQ-011 exp_i  in  ES  exponent.
REQ-012 mant_i  in  WIDTH  fraction, MSB-aligned, hidden 1 excluded; value = (-1)^s*16^k*2^e*(1+mant/2^WIDTH).
REQ-013 nar_i  in  1  force NaR.
REQ-014 zero_i  in  1  force zero.
REQ-015 rnd_mode_i  in  3  000 RNE, 001 RTZ; all other codes behave as RNE.
REQ-016 tag_i  in  1  sideband, passed through with the data.
REQ-017 flush_i  in  1  synchronous pipeline kill.
REQ-018 result_o  out  WIDTH  encoded posit.
REQ-019 tag_o  out  1  tag of result_o.
REQ-020 out_valid_o  out  1  result_o valid.
REQ-021 out_ready_i  in  1  downstream accepts.
REQ-022 busy_o  out  1  any pipeline stage holds valid data.

Function
REQ-023 Pipeline SHALL have two register stages: S1 builds the regime/exponent/fraction body; S2 rounds, saturates and applies sign. Latency is 2 cycles at full throughput.
REQ-024 Stage n SHALL load when it is empty or stage n+1 loads (S2 loads when empty or out_ready_i=1); in_ready_o = S1 loads condition, combinational.
REQ-025 Transfer at input/output SHALL occur only when valid and ready are both 1; held data and tag remain stable while out_valid_o=1 and out_ready_i=0.
REQ-026 Body: k>=0 gives k+1 ones then a zero; k<0 gives -k zeros then a one; then ES exponent bits, then mantissa; the top WIDTH-1 bits are kept, next bit = guard, OR of the rest = sticky.
REQ-027 RNE SHALL increment the kept body when guard=1 and (sticky=1 or kept LSB=1); RTZ SHALL truncate.
REQ-028 k >= WIDTH-2 SHALL give maxpos magnitude 0x7FFFFFFF; k <= -(WIDTH-2) SHALL give minpos 0x00000001; a nonzero input SHALL never encode as 0 or NaR.
REQ-029 sign_i=1 SHALL output the two's complement of {0, rounded body}.
REQ-030 nar_i=1 SHALL output 0x80000000 (priority over zero_i); zero_i=1 SHALL output 0x00000000; rnd_mode_i is ignored for both.
REQ-031 flush_i=1 SHALL clear both stage valids at the next edge; the input is not accepted that cycle; in_ready_o is forced to 0.
REQ-032 busy_o SHALL equal OR of the S1 and S2 valid bits.
REQ-033 Simultaneous output accept and input accept SHALL keep the pipeline full with no bubble.

Reset
REQ-034 While rst_i=1: out_valid_o=0, busy_o=0, result_o=0, tag_o=0, all stage valids 0, independent of clk_i.
REQ-035 Reset asserted mid-operation SHALL discard in-flight data; after release, the first result is the first input accepted after release.
REQ-036 in_ready_o SHALL be 1 while the pipeline is empty, including in the first cycle after reset.

Verification
REQ-037 s=0,k=0,e=0,mant=0 -> 0x40000000 two cycles later; s=1, same fields -> 0xC0000000; k=0,e=1,mant=0x1C000000 -> 0x48E00000.
REQ-038 k=0,e=0,mant=0x00000010, RNE -> 0x40000000 (tie to even); mant=0x00000030, RNE -> 0x40000002, RTZ -> 0x40000001.
REQ-039 k=31 -> 0x7FFFFFFF; k=-31 -> 0x00000001; nar_i=1 with zero_i=1 -> 0x80000000; zero_i=1 -> 0x00000000.
REQ-040 Stream 8 inputs back-to-back with out_ready_i toggling 1,0,0,1,... -> 8 results in order, each with its tag, none lost or duplicated; in_ready_o=0 only while both stages are full and out_ready_i=0.
REQ-041 Two inputs in flight, flush_i pulsed for 1 cycle -> out_valid_o=0 and busy_o=0 the next cycle; the next input is output 2 cycles after its acceptance.
REQ-042 rst_i asserted asynchronously with the pipeline full -> outputs go to 0 immediately, before the next edge; normal operation resumes after release.
